cnt_serial_tx: RTL and testbench

CNT_SERIAL_TX -- requirements
Module: cnt_serial_tx

---
 rtl/cnt_serial_tx.sv | 211 +++++++++++++++++++++
 tb/tb_cnt_serial_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_serial_tx.sv
// Serialises 4-bit counter values from a 2-entry FIFO as UART-like frames (start, d0..d3, stop).
// Define CNT_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module cnt_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] I_CNT,
    input  logic       I_VALID,
    output logic       O_READY,
    output logic       O_TXD,
    output logic       O_BUSY,
    output logic [7:0] O_FRAMES
);

    localparam logic [7:0] CLK_LAST = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef CNT_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_t;

`ifdef CNT_TX_PARITY_EN
    function automatic logic even_parity(input logic [3:0] data);
        return ^data;
    endfunction
`endif

    state_t      state_r;
    logic [7:0]  clk_cnt_r;
    logic [1:0]  bit_cnt_r;
    logic [3:0]  shift_r;
    logic        txd_r;
    logic        busy_r;
    logic [7:0]  frames_r;
`ifdef CNT_TX_PARITY_EN
    logic        parity_r;
`endif

    logic [3:0]  fifo_mem_r [0:1];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  fifo_cnt_r;
    logic        ready_r;

    logic        push_s;
    logic        pop_s;
    logic        last_clk_s;
    logic [3:0]  head_s;
    logic [1:0]  fifo_cnt_nxt_s;

    // Handshake, pop decision and next FIFO occupancy
    always_comb begin
        push_s     = I_VALID & ready_r;
        last_clk_s = (clk_cnt_r == CLK_LAST);
        head_s     = fifo_mem_r[rd_ptr_r];
        pop_s      = 1'b0;
        if (fifo_cnt_r != 2'd0) begin
            case (state_r)
                ST_IDLE: pop_s = 1'b1;
                ST_STOP: pop_s = last_clk_s;
                default: pop_s = 1'b0;
            endcase
        end else begin
            pop_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + 2'd1;
            2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - 2'd1;
            default: fifo_cnt_nxt_s = fifo_cnt_r;
        endcase
    end

    // Two-entry FIFO; ready reflects stored occupancy only, never a same-cycle pop
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fifo_mem_r[0] <= 4'd0;
            fifo_mem_r[1] <= 4'd0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            fifo_cnt_r    <= 2'd0;
            ready_r       <= 1'b1;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= I_CNT;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            fifo_cnt_r <= fifo_cnt_nxt_s;
            ready_r    <= (fifo_cnt_nxt_s < 2'd2);
        end
    end

    // Frame sequencer with registered line, busy flag and frame counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            clk_cnt_r <= 8'd0;
            bit_cnt_r <= 2'd0;
            shift_r   <= 4'd0;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
            frames_r  <= 8'd0;
`ifdef CNT_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    clk_cnt_r <= 8'd0;
                    bit_cnt_r <= 2'd0;
                    if (pop_s) begin
                        state_r <= ST_START;
                        shift_r <= head_s;
`ifdef CNT_TX_PARITY_EN
                        parity_r <= even_parity(head_s);
`endif
                        txd_r   <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        txd_r  <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (last_clk_s) begin
                        state_r   <= ST_DATA;
                        clk_cnt_r <= 8'd0;
                        txd_r     <= shift_r[0];
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 8'd1;
                    end
                end
                ST_DATA: begin
                    if (last_clk_s) begin
                        clk_cnt_r <= 8'd0;
                        if (bit_cnt_r == 2'd3) begin
                            bit_cnt_r <= 2'd0;
`ifdef CNT_TX_PARITY_EN
                            state_r   <= ST_PARITY;
                            txd_r     <= parity_r;
`else
                            state_r   <= ST_STOP;
                            txd_r     <= 1'b1;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 2'd1;
                            shift_r   <= {1'b0, shift_r[3:1]};
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 8'd1;
                    end
                end
`ifdef CNT_TX_PARITY_EN
                ST_PARITY: begin
                    if (last_clk_s) begin
                        state_r   <= ST_STOP;
                        clk_cnt_r <= 8'd0;
                        txd_r     <= 1'b1;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 8'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (last_clk_s) begin
                        clk_cnt_r <= 8'd0;
                        frames_r  <= frames_r + 8'd1;
                        // Back-to-back frames: the next start bit follows the stop bit directly
                        if (pop_s) begin
                            state_r <= ST_START;
                            shift_r <= head_s;
`ifdef CNT_TX_PARITY_EN
                            parity_r <= even_parity(head_s);
`endif
                            txd_r   <= 1'b0;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            txd_r   <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    clk_cnt_r <= 8'd0;
                    bit_cnt_r <= 2'd0;
                    txd_r     <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign O_READY  = ready_r;
    assign O_TXD    = txd_r;
    assign O_BUSY   = busy_r;
    assign O_FRAMES = frames_r;

endmodule

// File: tb/tb_cnt_serial_tx.sv
// Directed self-checking bench for cnt_serial_tx (CLKS_PER_BIT=4), honouring CNT_TX_PARITY_EN.
module tb_cnt_serial_tx;

    localparam int CPB = 4;
`ifdef CNT_TX_PARITY_EN
    localparam int NBITS = 7;
`else
    localparam int NBITS = 6;
`endif
    localparam int FL = NBITS * CPB;

    logic       CLK;
    logic       RST;
    logic [3:0] I_CNT;
    logic       I_VALID;
    logic       O_READY;
    logic       O_TXD;
    logic       O_BUSY;
    logic [7:0] O_FRAMES;

    int   total = 0;
    int   bad   = 0;
    logic txq [$];
    logic exp_q [$];
    logic cap_en = 1'b0;
    int   cap_max = 0;
    int   busy_hi = 0;

    cnt_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .I_CNT    (I_CNT),
        .I_VALID  (I_VALID),
        .O_READY  (O_READY),
        .O_TXD    (O_TXD),
        .O_BUSY   (O_BUSY),
        .O_FRAMES (O_FRAMES)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Line capture on the falling edge, away from the active edge
    always @(negedge CLK) begin
        if (cap_en && txq.size() < cap_max) begin
            txq.push_back(O_TXD);
            busy_hi = busy_hi + (O_BUSY ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_frame(input logic [3:0] v);
        for (int c = 0; c < CPB; c++) exp_q.push_back(1'b0);
        for (int b = 0; b < 4; b++)
            for (int c = 0; c < CPB; c++) exp_q.push_back(v[b]);
`ifdef CNT_TX_PARITY_EN
        for (int c = 0; c < CPB; c++) exp_q.push_back(^v);
`endif
        for (int c = 0; c < CPB; c++) exp_q.push_back(1'b1);
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_len"}, txq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < txq.size())
                check($sformatf("%s_bit%0d", tag, i), {31'd0, txq[i]}, {31'd0, exp_q[i]});
        end
    endtask

    task automatic run_single(input logic [3:0] v, input string tag);
        txq.delete();
        exp_q.delete();
        build_frame(v);
        busy_hi = 0;
        cap_max = FL;
        I_CNT   = v;
        I_VALID = 1'b1;
        check({tag, "_ready"}, O_READY, 1'b1);
        step();
        I_VALID = 1'b0;
        check({tag, "_txd_after_accept"}, O_TXD, 1'b1);
        check({tag, "_busy_after_accept"}, O_BUSY, 1'b0);
        step();
        cap_en = 1'b1;
        repeat (FL) step();
        cap_en = 1'b0;
        check({tag, "_busy_end"}, O_BUSY, 1'b0);
        check({tag, "_busy_cycles"}, busy_hi, FL);
        compare_q(tag);
    endtask

    initial begin
        int accepted;
        int cyc;
        logic rdy;

        RST = 1'b0;
        I_VALID = 1'b0;
        I_CNT = 4'd0;
        #1;
        RST = 1'b1;
        #1;
        check("rst_txd", O_TXD, 1'b1);
        check("rst_busy", O_BUSY, 1'b0);
        check("rst_frames", O_FRAMES, 8'd0);
        check("rst_ready", O_READY, 1'b1);
        repeat (3) step();
        RST = 1'b0;
        step();
        check("rel_txd", O_TXD, 1'b1);
        check("rel_busy", O_BUSY, 1'b0);
        check("rel_ready", O_READY, 1'b1);

        // Single frame of 4'b1011
        run_single(4'b1011, "single");
        check("single_frames", O_FRAMES, 8'd1);
        check("single_txd_idle", O_TXD, 1'b1);

        // Backpressure: 1,2,3 accepted back to back, 4 waits for the first pop
        txq.delete();
        exp_q.delete();
        build_frame(4'd1);
        build_frame(4'd2);
        build_frame(4'd3);
        build_frame(4'd4);
        cap_max = 4 * FL;
        busy_hi = 0;
        I_CNT = 4'd1;
        I_VALID = 1'b1;
        check("bp_ready0", O_READY, 1'b1);
        step();
        I_CNT = 4'd2;
        check("bp_ready1", O_READY, 1'b1);
        step();
        cap_en = 1'b1;
        I_CNT = 4'd3;
        check("bp_ready2", O_READY, 1'b1);
        step();
        check("bp_full", O_READY, 1'b0);
        I_CNT = 4'd4;
        repeat (FL - 2) step();
        check("bp_full_before_pop", O_READY, 1'b0);
        step();
        check("bp_ready_after_pop", O_READY, 1'b1);
        step();
        I_VALID = 1'b0;
        check("bp_full_after_4", O_READY, 1'b0);
        cyc = 0;
        while (txq.size() < cap_max && cyc < 8 * FL) begin
            step();
            cyc++;
        end
        cap_en = 1'b0;
        check("bp_busy_end", O_BUSY, 1'b0);
        check("bp_frames", O_FRAMES, 8'd5);
        check("bp_busy_cycles", busy_hi, 4 * FL);
        compare_q("bp");

        // Reset in the middle of the data bits of 4'hA with 4'h5 buffered
        I_CNT = 4'hA;
        I_VALID = 1'b1;
        step();
        I_CNT = 4'h5;
        step();
        I_VALID = 1'b0;
        repeat (6) step();
        check("mid_busy", O_BUSY, 1'b1);
        check("mid_txd_d0", O_TXD, 1'b0);
        RST = 1'b1;
        #1;
        check("mid_rst_txd", O_TXD, 1'b1);
        check("mid_rst_busy", O_BUSY, 1'b0);
        check("mid_rst_frames", O_FRAMES, 8'd0);
        check("mid_rst_ready", O_READY, 1'b1);
        #29;
        RST = 1'b0;
        step();
        check("mid_rel_txd", O_TXD, 1'b1);
        check("mid_rel_busy", O_BUSY, 1'b0);
        check("mid_rel_ready", O_READY, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step();
            check($sformatf("mid_idle_txd%0d", i), O_TXD, 1'b1);
            check($sformatf("mid_idle_busy%0d", i), O_BUSY, 1'b0);
        end
        check("mid_idle_frames", O_FRAMES, 8'd0);
        run_single(4'h6, "post_rst");
        check("post_rst_frames", O_FRAMES, 8'd1);

        // 256 consecutive frames wrap the frame counter back to zero
        RST = 1'b1;
        step();
        RST = 1'b0;
        step();
        accepted = 0;
        cyc = 0;
        while (accepted < 256 && cyc < 300 * FL) begin
            I_CNT = accepted[3:0];
            I_VALID = 1'b1;
            rdy = O_READY;
            step();
            if (rdy) accepted++;
            cyc++;
        end
        I_VALID = 1'b0;
        check("wrap_accepted", accepted, 256);
        cyc = 0;
        while (O_FRAMES !== 8'd255 && cyc < 10 * FL) begin
            step();
            cyc++;
        end
        check("wrap_255", O_FRAMES, 8'd255);
        cyc = 0;
        while (O_BUSY !== 1'b0 && cyc < 10 * FL) begin
            step();
            cyc++;
        end
        check("wrap_busy_end", O_BUSY, 1'b0);
        check("wrap_zero", O_FRAMES, 8'd0);
        check("wrap_txd", O_TXD, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
